// File: rtl/modmul_pkg.sv
// Shared types for the serial modular multiplier: FSM states and operation modes.
package modmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL   = 1'b0,
    MODE_TRANS = 1'b1
  } mode_e;

endpackage

// File: rtl/modmul_step.sv
// One interleaved iteration: (2r [+ a]) mod n, assuming r < n and a < n.
module modmul_step #(
  parameter int unsigned WIDTH = 256
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  input  logic             add_en,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_red;

  // Each partial value stays below 2n, so one conditional subtract suffices.
  always_comb begin
    dbl     = {r, 1'b0};
    dbl_red = (dbl >= {1'b0, n}) ? dbl - {1'b0, n} : dbl;
    sum     = {1'b0, dbl_red[WIDTH-1:0]} + (add_en ? {1'b0, a} : '0);
    sum_red = (sum >= {1'b0, n}) ? sum - {1'b0, n} : sum;
    res     = sum_red[WIDTH-1:0];
  end

endmodule

// File: rtl/modmul_serial.sv
// Bit-serial modular multiplier / Montgomery-domain transform, one operand bit per cycle.
module modmul_serial
  import modmul_pkg::*;
#(
  parameter int unsigned WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic             err_q;
  logic             op_valid;
  logic             add_en;
  logic [WIDTH-1:0] step_res;

  assign op_valid = (i_n >= WIDTH'(2)) && (i_a < i_n);
  // b is shifted left each iteration so its MSB is always the current bit.
  assign add_en   = (mode_q == MODE_MUL) && b_q[WIDTH-1];

  modmul_step #(.WIDTH(WIDTH)) u_step (
    .r      (acc_q),
    .a      (a_q),
    .n      (n_q),
    .add_en (add_en),
    .res    (step_res)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = op_valid ? RUN : DONE;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q == RUN) || (state_q == DONE);
    o_finished = (state_q == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (op_valid) begin
              mode_q <= mode_e'(i_mode);
              a_q    <= i_a;
              b_q    <= i_b;
              n_q    <= i_n;
              cnt_q  <= CW'(WIDTH - 1);
              acc_q  <= i_mode ? i_a : '0;
              err_q  <= 1'b0;
            end else begin
              acc_q  <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= step_res;
          b_q   <= {b_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_result = acc_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_modmul_serial.sv
// Randomized self-checking bench for modmul_serial at WIDTH=8 and WIDTH=256.
module tb_modmul_serial;

  localparam int unsigned W8   = 8;
  localparam int unsigned W256 = 256;
  localparam int          NOPS = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            s8 = 1'b0, m8 = 1'b0;
  logic [W8-1:0]   a8 = '0, b8 = '0, n8 = '0;
  logic [W8-1:0]   r8;
  logic            f8, bz8, e8;

  logic            s2 = 1'b0, m2 = 1'b0;
  logic [W256-1:0] a2 = '0, b2 = '0, n2 = '0;
  logic [W256-1:0] r2;
  logic            f2, bz2, e2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  modmul_serial #(.WIDTH(W8)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_start(s8), .i_mode(m8),
    .i_a(a8), .i_b(b8), .i_n(n8),
    .o_result(r8), .o_finished(f8), .o_busy(bz8), .o_err(e8)
  );

  modmul_serial #(.WIDTH(W256)) dut256 (
    .i_clk(clk), .i_rst(rst_n), .i_start(s2), .i_mode(m2),
    .i_a(a2), .i_b(b2), .i_n(n2),
    .o_result(r2), .o_finished(f2), .o_busy(bz2), .o_err(e2)
  );

  // Reference: plain wide arithmetic, a*b mod n or a*2^w mod n; rejected operands give 0.
  function automatic logic [255:0] ref_mod(input logic m, input logic [255:0] a, b, n,
                                           input int w);
    logic [511:0] x;
    if (n < 256'd2 || a >= n) return '0;
    x = m ? ({256'b0, a} << w) : ({256'b0, a} * {256'b0, b});
    return 256'(x % {256'b0, n});
  endfunction

  function automatic logic ref_err(input logic [255:0] a, n);
    return (n < 256'd2) || (a >= n);
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts one WIDTH=8 operation and waits (bounded) for its finish pulse; lat=-1 on timeout.
  task automatic run8(input logic m, input logic [7:0] a, b, n,
                      output logic [7:0] res, output logic err, output int lat);
    @(negedge clk);
    m8 = m; a8 = a; b8 = b; n8 = n; s8 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      s8 = 1'b0;
      lat++;
    end while (!f8 && lat < 40);
    if (!f8) lat = -1;
    res = r8;
    err = e8;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({r8, f8, bz8, e8} !== '0) $display("FAIL reset8 got r=%0d f=%b b=%b e=%b want all 0", r8, f8, bz8, e8);
    else pass_cnt++;
    total++;
    if ({r2, f2, bz2, e2} !== '0) $display("FAIL reset256 got f=%b b=%b e=%b r=%h want all 0", f2, bz2, e2, r2);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_vector;
    logic [7:0] res; logic err; int lat;
    run8(1'b0, 8'd100, 8'd200, 8'd251, res, err, lat);
    total++;
    if (lat !== 9) begin $display("FAIL mul_latency got %0d want 9", lat); end else pass_cnt++;
    total++;
    if (res !== 8'(ref_mod(1'b0, 100, 200, 251, 8)) || res !== 8'd171)
      $display("FAIL mul_result got %0d want 171", res);
    else pass_cnt++;
    total++;
    if (err !== 1'b0) $display("FAIL mul_err got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_trans_vector;
    logic [7:0] res; logic err; int lat;
    run8(1'b1, 8'd5, 8'd77, 8'd251, res, err, lat);
    total++;
    if (res !== 8'd25) $display("FAIL trans_result got %0d want 25", res); else pass_cnt++;
    total++;
    if (lat !== 9) $display("FAIL trans_latency got %0d want 9", lat); else pass_cnt++;
    @(negedge clk);
    total++;
    if (f8 !== 1'b0) $display("FAIL trans_pulse_width finished still %b want 0", f8); else pass_cnt++;
    total++;
    if (r8 !== 8'd25) $display("FAIL trans_hold got %0d want 25", r8); else pass_cnt++;
  endtask

  task automatic test_errors;
    logic [7:0] res; logic err; int lat;
    run8(1'b0, 8'd251, 8'd3, 8'd251, res, err, lat);
    total++;
    if ({lat == 1, res, err} !== {1'b1, 8'd0, 1'b1})
      $display("FAIL err_a_ge_n got lat=%0d r=%0d e=%b want lat=1 r=0 e=1", lat, res, err);
    else pass_cnt++;
    run8(1'b0, 8'd0, 8'd5, 8'd1, res, err, lat);
    total++;
    if ({lat == 1, res, err} !== {1'b1, 8'd0, 1'b1})
      $display("FAIL err_n1 got lat=%0d r=%0d e=%b want lat=1 r=0 e=1", lat, res, err);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (e8 !== 1'b1 || bz8 !== 1'b0) $display("FAIL err_sticky got e=%b busy=%b want e=1 busy=0", e8, bz8);
    else pass_cnt++;
    run8(1'b1, 8'd1, 8'd0, 8'd2, res, err, lat);
    total++;
    if ({lat == 9, res, err} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL err_clear got lat=%0d r=%0d e=%b want lat=9 r=0 e=0", lat, res, err);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    logic [7:0] expr; int lat;
    expr = 8'(ref_mod(1'b0, 77, 190, 233, 8));
    @(negedge clk);
    m8 = 1'b0; a8 = 8'd77; b8 = 8'd190; n8 = 8'd233; s8 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) s8 = 1'b0;
      if (lat == 3) begin
        total++;
        if (bz8 !== 1'b1) $display("FAIL ignore_busy got %b want 1", bz8); else pass_cnt++;
        m8 = 1'b1; a8 = 8'd1; b8 = 8'd1; n8 = 8'd3; s8 = 1'b1;
      end
      if (lat == 5) s8 = 1'b0;
    end while (!f8 && lat < 40);
    total++;
    if (lat !== 9) $display("FAIL ignore_latency got %0d want 9", lat); else pass_cnt++;
    total++;
    if (r8 !== expr || e8 !== 1'b0) $display("FAIL ignore_result got %0d e=%b want %0d e=0", r8, e8, expr);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] res; logic err; int lat; int viol;
    @(negedge clk);
    m8 = 1'b0; a8 = 8'd200; b8 = 8'd255; n8 = 8'd211; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({r8, f8, bz8, e8} !== '0) $display("FAIL midrun_reset got r=%0d f=%b b=%b e=%b want all 0", r8, f8, bz8, e8);
    else pass_cnt++;
    viol = 0;
    repeat (3) begin @(negedge clk); if (f8 || bz8) viol++; end
    rst_n = 1'b1;
    repeat (15) begin @(negedge clk); if (f8 || bz8 || r8 !== 8'd0) viol++; end
    total++;
    if (viol !== 0) $display("FAIL midrun_no_finish got %0d bad cycles want 0", viol); else pass_cnt++;
    run8(1'b0, 8'd200, 8'd255, 8'd211, res, err, lat);
    total++;
    if (res !== 8'(ref_mod(1'b0, 200, 255, 211, 8)) || lat !== 9)
      $display("FAIL midrun_restart got r=%0d lat=%0d want r=%0d lat=9", res, lat, 8'(ref_mod(1'b0, 200, 255, 211, 8)));
    else pass_cnt++;
  endtask

  task automatic test_random8;
    logic [7:0] a, b, n, res; logic m, err; int lat;
    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 4))
        0: n = 8'($urandom_range(0, 3));
        1: n = 8'd255;
        default: n = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: a = n - 8'd1;
        1: a = 8'($urandom);
        default: a = (n == 0) ? 8'd0 : 8'($urandom % n);
      endcase
      run8(m, a, b, n, res, err, lat);
      total++;
      if (res !== 8'(ref_mod(m, a, b, n, 8)) || err !== ref_err(a, n))
        $display("FAIL rand8 m=%b a=%0d b=%0d n=%0d got r=%0d e=%b want r=%0d e=%b",
                 m, a, b, n, res, err, 8'(ref_mod(m, a, b, n, 8)), ref_err(a, n));
      else pass_cnt++;
      total++;
      if (lat !== (ref_err(a, n) ? 1 : 9)) $display("FAIL rand8_latency got %0d want %0d", lat, ref_err(a, n) ? 1 : 9);
      else pass_cnt++;
    end
  endtask

  task automatic pick256(output logic m, output logic [255:0] a, b, n);
    m = 1'($urandom);
    b = rand256();
    case ($urandom_range(0, 3))
      0: n = rand256() | 256'd1;
      1: n = rand256() & ~256'd1;
      2: n = '1 - 256'($urandom_range(0, 1000));
      default: n = 256'($urandom_range(2, 1000));
    endcase
    if (n < 256'd2) n = 256'd4;
    a = ($urandom_range(0, 7) == 0) ? n - 256'd1 : rand256() % n;
  endtask

  task automatic test_back_to_back256;
    logic m; logic [255:0] a, b, n, expr; int gap;
    pick256(m, a, b, n);
    expr = ref_mod(m, a, b, n, W256);
    @(negedge clk);
    m2 = m; a2 = a; b2 = b; n2 = n; s2 = 1'b1;
    for (int i = 0; i < NOPS; i++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!f2 && gap < 600);
      total++;
      if (gap !== ((i == 0) ? W256 + 1 : W256 + 2))
        $display("FAIL b2b_spacing op=%0d got %0d want %0d", i, gap, (i == 0) ? W256 + 1 : W256 + 2);
      else pass_cnt++;
      total++;
      if (r2 !== expr || e2 !== 1'b0)
        $display("FAIL b2b_result op=%0d m=%b got %h e=%b want %h", i, m, r2, e2, expr);
      else pass_cnt++;
      if (i < NOPS - 1) begin
        pick256(m, a, b, n);
        expr = ref_mod(m, a, b, n, W256);
        m2 = m; a2 = a; b2 = b; n2 = n;
      end else begin
        s2 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (bz2 !== 1'b0) $display("FAIL b2b_idle busy=%b want 0", bz2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul_vector();
    test_trans_vector();
    test_errors();
    test_ignore_start();
    test_reset_midrun();
    test_random8();
    test_back_to_back256();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
